// File: rtl/xt_fetch_pkg.sv
// rtl/xt_fetch_pkg.sv - shared types and constants for the x_t stream fetcher
package xt_fetch_pkg;

    localparam int XT_ROM_LAT   = 2;
    localparam int XT_DATA_W    = 16;
    localparam int XT_TILE_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } xt_fetch_state_e;

    typedef logic signed [XT_TILE_SIZE-1:0][XT_DATA_W-1:0] xt_tile_t;

endpackage

// File: rtl/xt_fetch_fifo.sv
// rtl/xt_fetch_fifo.sv - tile FIFO with a registered head slot in front of DEPTH storage entries
module xt_fetch_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [PW:0]  occ
);

    localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          slot_free;
    logic          mem_wr;
    logic          mem_rd;

    // The head slot is refilled from storage first; an empty queue lets a capture bypass into it.
    assign slot_free = !valid || pop_ready;
    assign mem_rd    = slot_free && (occ != '0);
    assign mem_wr    = push && !(slot_free && (occ == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            valid  <= 1'b0;
            data   <= '0;
        end else begin
            if (slot_free) begin
                if (mem_rd) begin
                    data   <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                    valid  <= 1'b1;
                end else if (push) begin
                    data  <= push_data;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end
            if (mem_wr) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({mem_wr, mem_rd})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_wr && !mem_rd && occ == FULL_OCC));
        end
    end

endmodule

// File: rtl/xt_stream_fetcher.sv
// rtl/xt_stream_fetcher.sv - ROM tile sequencer with elastic output stream; XT_FETCH_STATS_EN adds stall_cycles
module xt_stream_fetcher
    import xt_fetch_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = XT_DATA_W,
    parameter int TILE_SIZE  = XT_TILE_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          num_tiles,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic signed [DATA_W-1:0] rom_dout [TILE_SIZE],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_vec [TILE_SIZE],
    output logic                     out_last
`ifdef XT_FETCH_STATS_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = TILE_SIZE * DATA_W + 1;
    localparam logic [ADDR_W:0] ONE_TILE = (ADDR_W+1)'(1);

    xt_fetch_state_e   state;
    logic [ADDR_W:0]   remaining;
    logic [XT_ROM_LAT:0] tag_v;
    logic [XT_ROM_LAT:0] tag_last;
    logic [PW:0]       occ;
    logic [PW+1:0]     credit;
    logic              can_issue;
    logic [EW-1:0]     cap_entry;
    logic [EW-1:0]     head_entry;

    // Every tile between address issue and capture holds a FIFO slot in reserve.
    always_comb begin
        credit = {1'b0, occ};
        for (int i = 0; i <= XT_ROM_LAT; i++) begin
            credit = credit + (PW+2)'(tag_v[i]);
        end
    end
    assign can_issue = credit < (PW+2)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rom_en    <= 1'b0;
            done      <= 1'b0;
            rom_addr  <= '0;
            remaining <= '0;
            tag_v     <= '0;
            tag_last  <= '0;
        end else begin
            done                    <= 1'b0;
            tag_v[0]                <= 1'b0;
            tag_last[0]             <= 1'b0;
            tag_v[XT_ROM_LAT:1]     <= tag_v[XT_ROM_LAT-1:0];
            tag_last[XT_ROM_LAT:1]  <= tag_last[XT_ROM_LAT-1:0];
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_tiles == '0) begin
                            done <= 1'b1;
                        end else begin
                            rom_addr    <= base_addr;
                            tag_v[0]    <= 1'b1;
                            tag_last[0] <= (num_tiles == ONE_TILE);
                            remaining   <= num_tiles - 1'b1;
                            busy        <= 1'b1;
                            rom_en      <= 1'b1;
                            state       <= (num_tiles == ONE_TILE) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        rom_addr    <= rom_addr + 1'b1;
                        tag_v[0]    <= 1'b1;
                        tag_last[0] <= (remaining == ONE_TILE);
                        remaining   <= remaining - 1'b1;
                        if (remaining == ONE_TILE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rom_en <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cap_entry    = '0;
        cap_entry[0] = tag_last[XT_ROM_LAT];
        for (int i = 0; i < TILE_SIZE; i++) begin
            cap_entry[1 + i*DATA_W +: DATA_W] = rom_dout[i];
        end
    end

    xt_fetch_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_v[XT_ROM_LAT]),
        .push_data (cap_entry),
        .pop_ready (out_ready),
        .valid     (out_valid),
        .data      (head_entry),
        .occ       (occ)
    );

    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            out_vec[i] = head_entry[1 + i*DATA_W +: DATA_W];
        end
    end
    assign out_last = out_valid & head_entry[0];

`ifdef XT_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (busy && out_valid && !out_ready) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xt_stream_fetcher.sv
// tb/tb_xt_stream_fetcher.sv - self-checking bench for xt_stream_fetcher
module tb_xt_stream_fetcher;
    import xt_fetch_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [5:0]        base_addr = '0;
    logic [6:0]        num_tiles = '0;
    logic              out_ready = 1'b0;
    logic              busy, done, rom_en, out_valid, out_last;
    logic [5:0]        rom_addr;
    logic signed [15:0] rom_dout [4];
    logic signed [15:0] out_vec [4];
    logic signed [15:0] s1 [4];
    logic signed [15:0] s2 [4];
`ifdef XT_FETCH_STATS_EN
    logic [31:0]       stall_cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int base;
        int n;
        int stall_at;
        int stall_len;
        int restart_at;
        int exp_done;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    xt_stream_fetcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_tiles    (num_tiles),
        .busy         (busy),
        .done         (done),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_dout     (rom_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vec      (out_vec),
        .out_last     (out_last)
`ifdef XT_FETCH_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // ROM model: word at address a holds elements a, a+1, a+2, a+3; two-cycle read latency.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            s1[j] <= 16'(rom_addr) + 16'(j);
            s2[j] <= s1[j];
        end
    end
    always_comb begin
        for (int j = 0; j < 4; j++) rom_dout[j] = rom_en ? s2[j] : 16'sd0;
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        for (int j = 0; j < 4; j++) chk({tag, "_out_vec"}, out_vec[j], 0);
    endtask

    task automatic run_job(input vec_t v);
        int got = 0;
        int dones = 0;
        int done_cyc = -1;
        logic prev_stall = 1'b0;
        logic signed [15:0] prev_vec [4];
        logic prev_last = 1'b0;
        start = 1'b1;
        base_addr = 6'(v.base);
        num_tiles = 7'(v.n);
        out_ready = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                chk("busy_c1", busy, (v.n > 0));
                chk("rom_en_c1", rom_en, (v.n > 0));
                if (v.n > 0) chk("rom_addr_c1", rom_addr, v.base);
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_last", out_last, prev_last);
                for (int j = 0; j < 4; j++) chk("stall_vec", out_vec[j], prev_vec[j]);
            end
            start = 1'b0;
            if (c == v.restart_at) begin
                start = 1'b1;
                base_addr = 6'd40;
                num_tiles = 7'd3;
            end
            out_ready = !(v.stall_len > 0 && c >= v.stall_at && c < v.stall_at + v.stall_len);
            if (v.n == 0) begin
                chk("zero_rom_en", rom_en, 0);
                chk("zero_out_valid", out_valid, 0);
            end
            if (out_valid && out_ready) begin
                if (got >= v.n) begin
                    chk("extra_tile", got, v.n - 1);
                end else begin
                    for (int j = 0; j < 4; j++)
                        chk("tile_data", out_vec[j], ((v.base + got) % 64) + j);
                    chk("tile_last", out_last, (got == v.n - 1));
                    if (v.stall_len == 0) chk("tile_cycle", c, 4 + got);
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_last = out_last;
            for (int j = 0; j < 4; j++) prev_vec[j] = out_vec[j];
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = c;
                    chk("done_cycle", c, v.exp_done);
                    chk("busy_at_done", busy, 0);
                end
            end else if (dones == 0 && v.n > 0) begin
                chk("busy_run", busy, 1);
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        chk("tiles_delivered", got, v.n);
        chk("done_pulses", dones, 1);
`ifdef XT_FETCH_STATS_EN
        chk("stall_cycles", stall_cycles, v.stall_len);
`endif
    endtask

    initial begin
        vecs[0] = '{0, 4, 0, 0, 0, 8};
        vecs[1] = '{0, 0, 0, 0, 0, 1};
        vecs[2] = '{62, 4, 0, 0, 0, 8};
        vecs[3] = '{10, 1, 0, 0, 0, 5};
        vecs[4] = '{63, 64, 0, 0, 0, 68};
        vecs[5] = '{5, 16, 8, 10, 0, 30};
        vecs[6] = '{0, 8, 0, 0, 2, 12};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Reset while draining, then a fresh job.
        start = 1'b1;
        base_addr = 6'd30;
        num_tiles = 7'd4;
        out_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_outputs("post_reset");
        run_job('{20, 3, 0, 0, 0, 7});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
